// File: rtl/wb_burst_master.sv
// Wishbone burst master: runs one {we, addr, len} command as an incrementing burst (cti 010, last beat 111).
// Latency: a read strobes 1 cycle after accept, a write 1 cycle after its beat is taken; done/err 1 cycle after the last ack or the timeout.
// Backpressure: cmd_ready only in IDLE with SDRAM init done; wr_ready only in FETCH; read beats (rd_valid) cannot be stalled.
//
// Ports:
//   wb_clk_i, wb_rst_i          : clock, synchronous active-high reset
//   sdr_init_done               : gates acceptance of new commands only
//   cmd_valid/ready/we/addr/len : command handshake; len is beats minus one
//   wr_valid/ready/data/sel     : write beat source, one beat fetched per Wishbone beat
//   rd_valid/data/last          : registered read beats, one-cycle pulses
//   done, err, busy             : completion pulse, timeout-abort pulse, not-IDLE status
//   wb_*                        : Wishbone B4 registered-feedback master port
module wb_burst_master #(
    parameter int AW     = 26,
    parameter int DW     = 32,
    parameter int LW     = 8,
    parameter int TO_CYC = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            sdr_init_done,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [LW-1:0]   cmd_len,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [DW-1:0]   wr_data,
    input  logic [DW/8-1:0] wr_sel,
    output logic            rd_valid,
    output logic [DW-1:0]   rd_data,
    output logic            rd_last,
    output logic            done,
    output logic            err,
    output logic            busy,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_addr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [2:0]      wb_cti_o,
    input  logic            wb_ack_i,
    input  logic [DW-1:0]   wb_dat_i
);
    localparam int SW = DW / 8;
    // Counter must be able to hold TO_CYC-1; keep at least one bit.
    localparam int CW = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);

    localparam logic [AW-1:0] ADDR_STEP   = AW'(SW);
    localparam logic [CW-1:0] TO_LAST     = CW'(TO_CYC - 1);
    localparam logic [2:0]    CTI_CLASSIC = 3'b000;
    localparam logic [2:0]    CTI_INCR    = 3'b010;
    localparam logic [2:0]    CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_XFER  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [LW-1:0]   rem_q, rem_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_last_q, rd_last_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            cmd_acc;
    logic            wr_acc;
    logic            ack_acc;
    logic            last_beat;
    logic            to_hit;

    assign cmd_acc   = cmd_valid & cmd_ready;
    assign wr_acc    = wr_valid & wr_ready;
    // An ack only counts while we are strobing; stray acks in FETCH/IDLE are dropped.
    assign ack_acc   = wb_stb_o & wb_ack_i;
    assign last_beat = (rem_q == '0);
    // Counter value in the TO_CYC-th consecutive ack-less XFER cycle.
    assign to_hit    = (cnt_q == TO_LAST);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_acc) begin
                    state_d = cmd_we ? S_FETCH : S_XFER;
                end
            end
            S_FETCH: begin
                if (wr_acc) begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (ack_acc) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        // Writes need a fresh beat; reads keep stb high.
                        state_d = we_q ? S_FETCH : S_XFER;
                    end
                end else if (to_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        busy      = 1'b0;
        wb_cti_o  = CTI_CLASSIC;
        case (state_q)
            S_IDLE: begin
                // Handshakes are held off while reset is asserted.
                cmd_ready = sdr_init_done & ~wb_rst_i;
            end
            S_FETCH: begin
                wr_ready = ~wb_rst_i;
                wb_cyc_o = 1'b1;
                busy     = 1'b1;
                wb_cti_o = last_beat ? CTI_END : CTI_INCR;
            end
            S_XFER: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                busy     = 1'b1;
                wb_cti_o = last_beat ? CTI_END : CTI_INCR;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath next state
    // ---------------------------------------------------------------
    always_comb begin
        we_d       = we_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (cmd_acc) begin
                    we_d   = cmd_we;
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    // Reads fetch whole words; writes take lanes per beat.
                    if (!cmd_we) begin
                        sel_d = '1;
                    end
                end
            end
            S_FETCH: begin
                // Waiting on the write source is not a slave timeout.
                cnt_d = '0;
                if (wr_acc) begin
                    dat_d = wr_data;
                    sel_d = wr_sel;
                end
            end
            S_XFER: begin
                if (ack_acc) begin
                    cnt_d = '0;
                    if (!we_q) begin
                        rd_data_d  = wb_dat_i;
                        rd_valid_d = 1'b1;
                        rd_last_d  = last_beat;
                    end
                    if (last_beat) begin
                        done_d = 1'b1;
                    end else begin
                        // Wraps modulo 2^AW by construction.
                        addr_d = addr_q + ADDR_STEP;
                        rem_d  = rem_q - LW'(1);
                    end
                end else if (to_hit) begin
                    // Abort: remaining beats are discarded, no done.
                    cnt_d = '0;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            rem_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q       <= we_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign wb_we_o   = we_q & busy;
    assign wb_addr_o = addr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_last_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Testbench for wb_burst_master: table of burst vectors driven through a bench-side
// Wishbone slave and write source, plus hand sequences for reset, init gating,
// timeout abort and reset mid-burst.
module tb_wb_burst_master;
    localparam int AW     = 26;
    localparam int DW     = 32;
    localparam int LW     = 8;
    localparam int TO_CYC = 255;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i;
    logic            sdr_init_done;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_we;
    logic [AW-1:0]   cmd_addr;
    logic [LW-1:0]   cmd_len;
    logic            wr_valid;
    logic            wr_ready;
    logic [DW-1:0]   wr_data;
    logic [DW/8-1:0] wr_sel;
    logic            rd_valid;
    logic [DW-1:0]   rd_data;
    logic            rd_last;
    logic            done;
    logic            err;
    logic            busy;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [AW-1:0]   wb_addr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [2:0]      wb_cti_o;
    logic            wb_ack_i;
    logic [DW-1:0]   wb_dat_i;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_burst_master #(
        .AW(AW), .DW(DW), .LW(LW), .TO_CYC(TO_CYC)
    ) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .sdr_init_done(sdr_init_done),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_we       (cmd_we),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .wr_sel       (wr_sel),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .done         (done),
        .err          (err),
        .busy         (busy),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_we_o      (wb_we_o),
        .wb_addr_o    (wb_addr_o),
        .wb_dat_o     (wb_dat_o),
        .wb_sel_o     (wb_sel_o),
        .wb_cti_o     (wb_cti_o),
        .wb_ack_i     (wb_ack_i),
        .wb_dat_i     (wb_dat_i)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One burst: command, bench slave behaviour, and hand-computed expectations.
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int            ack_lat;       // stb cycles without ack before each ack
        int            stall;         // cycles wr_valid is withheld before beat 2
        logic [DW-1:0] wbase;         // write data of beat i is wbase+i
        int            exp_beats;
        logic [AW-1:0] exp_last_addr;
        logic [2:0]    exp_first_cti;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input vec_t v, input int id);
        int            beat;
        int            wait_cnt;
        int            rd_cnt;
        int            done_cnt;
        int            err_cnt;
        int            cyc;
        int            last_ack_cyc;
        int            done_cyc;
        int            stall_left;
        int            stall_bad;
        logic          finished;
        logic [AW-1:0] exp_a;
        logic [AW-1:0] last_a;
        logic [2:0]    first_cti;
        beat = 0; wait_cnt = 0; rd_cnt = 0; done_cnt = 0; err_cnt = 0;
        cyc = 0; last_ack_cyc = -10; done_cyc = -20; stall_left = v.stall; stall_bad = 0;
        finished = 1'b0; last_a = '0; first_cti = 3'b000;

        @(negedge wb_clk_i);
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        chk($sformatf("v%0d_accept_busy", id), 64'(busy), 64'(1));

        while (!finished && cyc < 400) begin
            // sample outputs of this cycle
            if (rd_valid) begin
                chk($sformatf("v%0d_rd_data_%0d", id, rd_cnt), 64'(rd_data), 64'(32'hC0DE_0000 + DW'(rd_cnt)));
                chk($sformatf("v%0d_rd_last_%0d", id, rd_cnt), 64'(rd_last), 64'(rd_cnt == v.exp_beats - 1));
                rd_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                finished = 1'b1;
                chk($sformatf("v%0d_cyc_low_at_done", id), 64'(wb_cyc_o), 64'(0));
            end
            if (err) begin
                err_cnt++;
                finished = 1'b1;
            end
            // drive inputs for this cycle
            wb_ack_i = 1'b0;
            wr_valid = 1'b0;
            if (cyc == 0 && v.stall > 0) sdr_init_done = 1'b0;
            if (!finished) begin
                if (wr_ready) begin
                    if (beat == 1 && stall_left > 0) begin
                        stall_left--;
                        wb_ack_i = 1'b1;   // stray ack while stb is low
                        if (wb_stb_o || !wb_cyc_o) stall_bad++;
                    end else begin
                        wr_valid = 1'b1;
                        wr_data  = v.wbase + DW'(beat);
                        wr_sel   = 4'hF - 4'(beat);
                    end
                end
                if (wb_stb_o) begin
                    exp_a = v.addr + AW'(4 * beat);
                    chk($sformatf("v%0d_addr_b%0d", id, beat), 64'(wb_addr_o), 64'(exp_a));
                    chk($sformatf("v%0d_cti_b%0d", id, beat), 64'(wb_cti_o),
                        64'((beat == v.exp_beats - 1) ? 3'b111 : 3'b010));
                    if (beat == 0) first_cti = wb_cti_o;
                    if (wait_cnt == v.ack_lat) begin
                        wb_ack_i = 1'b1;
                        wb_dat_i = 32'hC0DE_0000 + DW'(beat);
                        chk($sformatf("v%0d_we_b%0d", id, beat), 64'(wb_we_o), 64'(v.we));
                        if (v.we) begin
                            chk($sformatf("v%0d_dat_b%0d", id, beat), 64'(wb_dat_o), 64'(v.wbase + DW'(beat)));
                            chk($sformatf("v%0d_sel_b%0d", id, beat), 64'(wb_sel_o), 64'(4'hF - 4'(beat)));
                        end
                        last_a   = wb_addr_o;
                        beat++;
                        wait_cnt = 0;
                        if (beat == v.exp_beats) last_ack_cyc = cyc;
                    end else begin
                        wait_cnt++;
                    end
                end
            end
            if (!finished) begin
                @(negedge wb_clk_i);
                cyc++;
            end
        end
        wb_ack_i      = 1'b0;
        wr_valid      = 1'b0;
        sdr_init_done = 1'b1;

        chk($sformatf("v%0d_beats", id), 64'(beat), 64'(v.exp_beats));
        chk($sformatf("v%0d_last_addr", id), 64'(last_a), 64'(v.exp_last_addr));
        chk($sformatf("v%0d_first_cti", id), 64'(first_cti), 64'(v.exp_first_cti));
        chk($sformatf("v%0d_done_cnt", id), 64'(done_cnt), 64'(1));
        chk($sformatf("v%0d_err_cnt", id), 64'(err_cnt), 64'(0));
        chk($sformatf("v%0d_done_timing", id), 64'(done_cyc), 64'(last_ack_cyc + 1));
        chk($sformatf("v%0d_rd_cnt", id), 64'(rd_cnt), 64'(v.we ? 0 : v.exp_beats));
        if (v.stall > 0) begin
            chk($sformatf("v%0d_stall_stb_low", id), 64'(stall_bad), 64'(0));
            chk($sformatf("v%0d_stall_used", id), 64'(stall_left), 64'(0));
        end
        @(negedge wb_clk_i);
        chk($sformatf("v%0d_done_pulse", id), 64'(done), 64'(0));
        chk($sformatf("v%0d_idle_busy", id), 64'(busy), 64'(0));
        if (busy) begin
            wb_rst_i = 1'b1;
            @(negedge wb_clk_i);
            wb_rst_i = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int stb_cnt;
        int saw_err;
        int saw_done;
        int rdv_cnt;
        int late_cnt;

        vecs[0] = '{we:1'b1, addr:26'h100,     len:8'd3, ack_lat:1, stall:0,  wbase:32'hA0,
                    exp_beats:4, exp_last_addr:26'h10C,     exp_first_cti:3'b010};
        vecs[1] = '{we:1'b0, addr:26'h3FFFFFC, len:8'd1, ack_lat:1, stall:0,  wbase:32'h0,
                    exp_beats:2, exp_last_addr:26'h0000000, exp_first_cti:3'b010};
        vecs[2] = '{we:1'b1, addr:26'h200,     len:8'd2, ack_lat:1, stall:20, wbase:32'hB0,
                    exp_beats:3, exp_last_addr:26'h208,     exp_first_cti:3'b010};
        vecs[3] = '{we:1'b0, addr:26'h40,      len:8'd0, ack_lat:0, stall:0,  wbase:32'h0,
                    exp_beats:1, exp_last_addr:26'h40,      exp_first_cti:3'b111};
        vecs[4] = '{we:1'b1, addr:26'h3FFFFFC, len:8'd0, ack_lat:3, stall:0,  wbase:32'h5500,
                    exp_beats:1, exp_last_addr:26'h3FFFFFC, exp_first_cti:3'b111};
        vecs[5] = '{we:1'b0, addr:26'h1000,    len:8'd4, ack_lat:2, stall:0,  wbase:32'h0,
                    exp_beats:5, exp_last_addr:26'h1010,    exp_first_cti:3'b010};

        // ---- reset state, with every input trying to provoke activity ----
        wb_rst_i = 1'b1; sdr_init_done = 1'b1; cmd_valid = 1'b1; cmd_we = 1'b1;
        cmd_addr = 26'h100; cmd_len = 8'd3; wr_valid = 1'b1; wr_data = 32'hFFFF_FFFF;
        wr_sel = 4'hF; wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        repeat (3) @(negedge wb_clk_i);
        chk("rst_cyc",       64'(wb_cyc_o),  64'(0));
        chk("rst_stb",       64'(wb_stb_o),  64'(0));
        chk("rst_we",        64'(wb_we_o),   64'(0));
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_wr_ready",  64'(wr_ready),  64'(0));
        chk("rst_busy",      64'(busy),      64'(0));
        chk("rst_done",      64'(done),      64'(0));
        chk("rst_err",       64'(err),       64'(0));
        chk("rst_rd_valid",  64'(rd_valid),  64'(0));
        chk("rst_rd_last",   64'(rd_last),   64'(0));
        chk("rst_rd_data",   64'(rd_data),   64'(0));
        chk("rst_addr",      64'(wb_addr_o), 64'(0));
        chk("rst_dat",       64'(wb_dat_o),  64'(0));
        chk("rst_sel",       64'(wb_sel_o),  64'(0));
        chk("rst_cti",       64'(wb_cti_o),  64'(0));
        cmd_valid = 1'b0; wr_valid = 1'b0; wb_ack_i = 1'b0; sdr_init_done = 1'b0;
        wb_rst_i = 1'b0;

        // ---- init_done gating, then accept in the same cycle it rises ----
        @(negedge wb_clk_i);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 26'h40; cmd_len = 8'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge wb_clk_i);
            chk($sformatf("init_gate_ready_%0d", i), 64'(cmd_ready), 64'(0));
            chk($sformatf("init_gate_cyc_%0d", i),   64'(wb_cyc_o),  64'(0));
        end
        sdr_init_done = 1'b1;
        #1;
        chk("init_rise_ready", 64'(cmd_ready), 64'(1));
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        chk("init_acc_busy", 64'(busy),      64'(1));
        chk("init_acc_stb",  64'(wb_stb_o),  64'(1));
        chk("init_acc_cti",  64'(wb_cti_o),  64'(3'b111));
        chk("init_acc_addr", 64'(wb_addr_o), 64'(26'h40));
        wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
        @(negedge wb_clk_i);
        wb_ack_i = 1'b0;
        chk("init_rd_valid", 64'(rd_valid), 64'(1));
        chk("init_rd_data",  64'(rd_data),  64'(32'h1234_5678));
        chk("init_rd_last",  64'(rd_last),  64'(1));
        chk("init_done",     64'(done),     64'(1));
        chk("init_cyc_low",  64'(wb_cyc_o), 64'(0));

        // ---- table-driven bursts ----
        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k], k);
        end

        // ---- read, slave never acks: timeout abort ----
        @(negedge wb_clk_i);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 26'h80; cmd_len = 8'd0;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        stb_cnt = 0; saw_err = 0; saw_done = 0; rdv_cnt = 0;
        for (int i = 0; i < 400 && saw_err == 0; i++) begin
            if (wb_stb_o) stb_cnt++;
            if (done) saw_done++;
            if (rd_valid) rdv_cnt++;
            if (err) begin
                saw_err = 1;
                chk("to_cyc_low", 64'(wb_cyc_o), 64'(0));
            end else begin
                @(negedge wb_clk_i);
            end
        end
        chk("to_err_seen",   64'(saw_err),  64'(1));
        chk("to_stb_cycles", 64'(stb_cnt),  64'(TO_CYC));
        chk("to_no_done",    64'(saw_done), 64'(0));
        chk("to_no_rdv",     64'(rdv_cnt),  64'(0));
        @(negedge wb_clk_i);
        chk("to_err_pulse",  64'(err),      64'(0));
        chk("to_idle",       64'(busy),     64'(0));

        // ---- reset after the 2nd ack of a len-7 read ----
        @(negedge wb_clk_i);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 26'h800; cmd_len = 8'd7;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0AAA;
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_ack_i = 1'b0;
        chk("mrst_pre_rdv",  64'(rd_valid),  64'(1));
        chk("mrst_pre_addr", 64'(wb_addr_o), 64'(26'h808));
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        chk("mrst_cyc",  64'(wb_cyc_o), 64'(0));
        chk("mrst_stb",  64'(wb_stb_o), 64'(0));
        chk("mrst_busy", 64'(busy),     64'(0));
        chk("mrst_done", 64'(done),     64'(0));
        chk("mrst_err",  64'(err),      64'(0));
        chk("mrst_rdv",  64'(rd_valid), 64'(0));
        wb_rst_i = 1'b0;
        wb_ack_i = 1'b1;   // stray acks with the bus idle
        late_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge wb_clk_i);
            if (rd_valid || done || err || wb_cyc_o) late_cnt++;
        end
        wb_ack_i = 1'b0;
        chk("mrst_quiet_after", 64'(late_cnt), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
